data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised data memory for the RISC-V datapath, replacing the fixed 32x32 word memory. Supports byte/half/word loads and stores (funct3-coded) with sign/zero extension, a valid/ready request handshake with configurable wait states, and alignment/range error reporting. After reset, a sweep state machine zero-fills the array. Sits between the ALU address/rs2 path and the writeback mux.

Parameters:
ADDR_W, 16, byte-address width.
DEPTH, 256, number of 32-bit words (power of two, 4..65536, DEPTH*4 <= 2^ADDR_W).
LAT, 1, wait cycles inserted before the array access (0..7).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
req_wdata  in  32  store data, LSB-aligned.
rsp_valid  out  1  one-cycle response strobe.
rsp_rdata  out  32  load result (extended), 0 for stores/errors.
rsp_err  out  1  request rejected (misaligned, out of range, illegal size).
busy_init  out  1  zero-fill sweep in progress.

Behaviour:
- Reset (async, rst=1): state INIT, clear index 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy_init=1.
- INIT: one word per cycle is written to 0, index 0..DEPTH-1; after the write of DEPTH-1 the state moves to IDLE. busy_init=1 for exactly DEPTH cycles after reset release. req_ready=0; requests are ignored.
- IDLE: req_ready=1. Handshake at a rising edge with req_valid&req_ready latches we/addr/size/wdata. Inputs are don't-care afterwards.
- WAIT: entered after acceptance; it lasts LAT cycles and is skipped when LAT=0. ACCESS lasts one cycle; its ending edge performs the array operation and registers the response.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 from acceptance through RESP inclusive. Latency from the acceptance edge to rsp_valid high is LAT+1 cycles. Back-to-back throughput is one request per LAT+3 cycles.
- rsp_rdata/rsp_err are updated only at the ACCESS edge and held until the next response.
- Addressing is little-endian. Word index = addr[ADDR_W-1:2], and byte lane = addr[1:0].
- Errors:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH.
  - Store size not in {000,001,010}.
  - Load size not in {000,001,010,100,101}.
- On error: no array write, rsp_rdata=0, rsp_err=1, and the timing is unchanged.
- Stores: sb writes lane addr[1:0] with wdata[7:0]. sh writes lanes addr[1]*2..+1 with wdata[15:0]. sw writes the full word. Other bytes are preserved. rsp_rdata=0 and rsp_err=0.
- Loads: lb/lh sign-extend the selected byte/half, lbu/lhu zero-extend it, and lw returns the word. rsp_err=0.
- Reset mid-operation aborts any pending request with no write and no response, then the INIT sweep reruns.
- No X on outputs at any time after reset.

Test Plan:
- DEPTH=16, LAT=1: pulse rst -> busy_init=1 for 16 cycles, req_ready=0 throughout; lw 0x3C after INIT -> rsp_rdata=0x00000000, rsp_err=0.
- sw 0x10 ← 0x8899AABB, then lb 0x13 -> 0xFFFFFF88; lbu 0x13 -> 0x00000088; lh 0x10 -> 0xFFFFAABB; lhu 0x12 -> 0x00008899.
- sw 0x20 ← 0x11223344, sb 0x21 ← 0x..EE, sh 0x22 ← 0x..5566 -> lw 0x20 = 0x5566EE44.
- lw 0x22, lh 0x01, lw 0x40 (DEPTH=16), req_size 011 -> each rsp_err=1, rsp_rdata=0, memory unchanged (lw 0x20 still 0x5566EE44).
- LAT=0 vs LAT=3: accept at edge t -> rsp_valid high in cycle t+1 resp. t+4, one cycle wide; req_valid held high continuously -> next accept exactly one cycle after rsp_valid.
- Assert rst during WAIT of sw 0x04 ← 0xDEADBEEF -> rsp_valid never fires, INIT reruns, lw 0x04 returns 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : byte/half/word data memory with valid/ready handshake,
//                 configurable wait states, error reporting and zero-fill sweep.
// Revision      : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy_init
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [2:0]       C_LAST_WAIT = 3'(LAT - 1);

  logic [2:0]        r_state, w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [2:0]        r_wcnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [31:0]       r_wdata;
  logic [31:0]       mem [DEPTH];

  logic              w_accept, w_size_bad, w_misalign, w_range, w_err;
  logic [IDX_W-1:0]  w_widx, w_mem_idx;
  logic [31:0]       w_rword, w_load, w_st_data, w_mem_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_st_be, w_mem_be;
  logic              w_mem_we;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   if (r_idx == C_LAST_IDX) w_next = S_IDLE;
      S_IDLE:   if (req_valid) w_next = (LAT == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_wcnt == C_LAST_WAIT) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_INIT;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    busy_init = (r_state == S_INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_size    <= '0;
      r_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_idx <= r_idx + 1'b1;
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 3'd1;
      if (w_accept) begin
        r_wcnt  <= '0;
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_wdata <= req_wdata;
      end
      if (r_state == S_ACCESS) begin
        rsp_err   <= w_err;
        rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
      end
    end
  end

  // Unsigned loads (bu/hu) have no store counterpart.
  always_comb begin
    w_size_bad = 1'b1;
    case (r_size)
      3'b000, 3'b001, 3'b010: w_size_bad = 1'b0;
      3'b100, 3'b101:         w_size_bad = r_we;
      default:                w_size_bad = 1'b1;
    endcase
  end

  assign w_misalign = ((r_size[1:0] == 2'b01) && r_addr[0]) ||
                      ((r_size == 3'b010) && (r_addr[1:0] != 2'b00));
  assign w_range    = 32'(r_addr[ADDR_W-1:2]) >= 32'(DEPTH);
  assign w_err      = w_size_bad || w_misalign || w_range;

  assign w_widx  = r_addr[IDX_W+1:2];
  assign w_rword = mem[w_widx];
  assign w_byte  = w_rword[{r_addr[1:0], 3'b000} +: 8];
  assign w_half  = r_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = w_rword;
    case (r_size)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_rword;
    endcase
  end

  always_comb begin
    w_st_be   = 4'b1111;
    w_st_data = r_wdata;
    case (r_size[1:0])
      2'b00: begin
        w_st_be   = 4'b0001 << r_addr[1:0];
        w_st_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_st_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // The zero-fill sweep and stores share a single write port.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = w_widx;
    w_mem_be   = w_st_be;
    w_mem_data = w_st_data;
    if (r_state == S_INIT) begin
      w_mem_we   = 1'b1;
      w_mem_idx  = r_idx;
      w_mem_be   = 4'b1111;
      w_mem_data = 32'd0;
    end else if ((r_state == S_ACCESS) && r_we && !w_err) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mem_be[b]) mem[w_mem_idx][8*b +: 8] <= w_mem_data[8*b +: 8];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// tb_data_mem_ctrl : directed table-driven bench for data_mem_ctrl, DEPTH=16,
// with three instances at LAT=1 (functional table), LAT=0 and LAT=3 (timing).
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [15:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic [2:0]  rdy, vld, err, busy;
  logic [2:0][31:0] rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(16), .DEPTH(16), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(vld[0]),
    .rsp_rdata(rd[0]), .rsp_err(err[0]), .busy_init(busy[0]));
  data_mem_ctrl #(.ADDR_W(16), .DEPTH(16), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(vld[1]),
    .rsp_rdata(rd[1]), .rsp_err(err[1]), .busy_init(busy[1]));
  data_mem_ctrl #(.ADDR_W(16), .DEPTH(16), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(vld[2]),
    .rsp_rdata(rd[2]), .rsp_err(err[2]), .busy_init(busy[2]));

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input int sel, input logic we, input logic [15:0] addr,
                        input logic [2:0] size, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic err_o, output int lat_o);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready timeout", {31'd0, rdy[sel]}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    n = 0;
    while (!vld[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rsp timeout", {31'd0, vld[sel]}, 32'd1);
    rd_o  = rd[sel];
    err_o = err[sel];
    lat_o = n;
  endtask

  // Continuous req_valid: response index, strobe width and next acceptance.
  task automatic thru(input int sel, input int lat);
    int r1, v, r2;
    r1 = -1; v = -1; r2 = -1;
    @(negedge clk);
    req_we = 1'b0; req_addr = 16'h0000; req_size = 3'b010; req_valid = 1'b1;
    for (int k = 0; k < 40 && r2 < 0; k++) begin
      if (r1 < 0 && rdy[sel]) r1 = k;
      else if (r1 >= 0 && v < 0 && vld[sel]) v = k;
      else if (v >= 0 && r2 < 0 && rdy[sel]) r2 = k;
      if (v >= 0 && k == v + 1) chk($sformatf("lat%0d strobe width", lat), {31'd0, vld[sel]}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk($sformatf("lat%0d accept-to-rsp", lat), 32'(v - r1), 32'(lat + 2));
    chk($sformatf("lat%0d rsp-to-accept", lat), 32'(r2 - v), 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic count_init(input string nm);
    int cnt;
    logic rdy_seen, vld_seen;
    cnt = 0; rdy_seen = 1'b0; vld_seen = 1'b0;
    while (busy[0] && cnt < 100) begin
      if (rdy[0]) rdy_seen = 1'b1;
      if (vld[0]) vld_seen = 1'b1;
      @(negedge clk);
      cnt++;
    end
    chk({nm, " busy cycles"}, 32'(cnt), 32'd16);
    chk({nm, " ready during init"}, {31'd0, rdy_seen}, 32'd0);
    chk({nm, " rsp during init"}, {31'd0, vld_seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] g_rd;
    logic        g_err;
    int          g_lat;

    tv[0]  = '{1'b0, 16'h003C, 3'b010, 32'h0,        32'h00000000, 1'b0};
    tv[1]  = '{1'b1, 16'h0010, 3'b010, 32'h8899AABB, 32'h00000000, 1'b0};
    tv[2]  = '{1'b0, 16'h0013, 3'b000, 32'h0,        32'hFFFFFF88, 1'b0};
    tv[3]  = '{1'b0, 16'h0013, 3'b100, 32'h0,        32'h00000088, 1'b0};
    tv[4]  = '{1'b0, 16'h0010, 3'b001, 32'h0,        32'hFFFFAABB, 1'b0};
    tv[5]  = '{1'b0, 16'h0012, 3'b101, 32'h0,        32'h00008899, 1'b0};
    tv[6]  = '{1'b1, 16'h0020, 3'b010, 32'h11223344, 32'h00000000, 1'b0};
    tv[7]  = '{1'b1, 16'h0021, 3'b000, 32'hCAFEBAEE, 32'h00000000, 1'b0};
    tv[8]  = '{1'b1, 16'h0022, 3'b001, 32'h12345566, 32'h00000000, 1'b0};
    tv[9]  = '{1'b0, 16'h0020, 3'b010, 32'h0,        32'h5566EE44, 1'b0};
    tv[10] = '{1'b0, 16'h0022, 3'b010, 32'h0,        32'h00000000, 1'b1};
    tv[11] = '{1'b0, 16'h0001, 3'b001, 32'h0,        32'h00000000, 1'b1};
    tv[12] = '{1'b0, 16'h0040, 3'b010, 32'h0,        32'h00000000, 1'b1};
    tv[13] = '{1'b0, 16'h0020, 3'b011, 32'h0,        32'h00000000, 1'b1};
    tv[14] = '{1'b1, 16'h0020, 3'b100, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tv[15] = '{1'b1, 16'h0022, 3'b010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tv[16] = '{1'b1, 16'h0023, 3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tv[17] = '{1'b0, 16'h0020, 3'b010, 32'h0,        32'h5566EE44, 1'b0};
    tv[18] = '{1'b0, 16'h0021, 3'b000, 32'h0,        32'hFFFFFFEE, 1'b0};
    tv[19] = '{1'b0, 16'h0022, 3'b101, 32'h0,        32'h00005566, 1'b0};
    tv[20] = '{1'b1, 16'h003C, 3'b010, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    tv[21] = '{1'b0, 16'h003C, 3'b010, 32'h0,        32'hA5A5A5A5, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    #1;
    chk("reset req_ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset rsp_valid", {31'd0, vld[0]}, 32'd0);
    chk("reset rsp_rdata", rd[0], 32'd0);
    chk("reset rsp_err", {31'd0, err[0]}, 32'd0);
    chk("reset busy_init", {31'd0, busy[0]}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_init("init");

    for (int i = 0; i < NV; i++) begin
      do_req(0, tv[i].we, tv[i].addr, tv[i].size, tv[i].wd, g_rd, g_err, g_lat);
      chk($sformatf("vec%0d rdata", i), g_rd, tv[i].exp_rd);
      chk($sformatf("vec%0d err", i), {31'd0, g_err}, {31'd0, tv[i].exp_err});
      chk($sformatf("vec%0d latency", i), 32'(g_lat), 32'd2);
    end

    repeat (10) @(negedge clk);
    do_req(1, 1'b0, 16'h0008, 3'b010, 32'h0, g_rd, g_err, g_lat);
    chk("lat0 latency", 32'(g_lat), 32'd1);
    repeat (10) @(negedge clk);
    do_req(2, 1'b0, 16'h0008, 3'b010, 32'h0, g_rd, g_err, g_lat);
    chk("lat3 latency", 32'(g_lat), 32'd4);
    repeat (10) @(negedge clk);
    thru(1, 0);
    thru(2, 3);

    // Reset while the LAT=1 instance sits in WAIT with a pending store.
    while (!rdy[0]) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0004; req_size = 3'b010;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset busy_init", {31'd0, busy[0]}, 32'd1);
    chk("midreset rsp_valid", {31'd0, vld[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_init("reinit");
    do_req(0, 1'b0, 16'h0004, 3'b010, 32'h0, g_rd, g_err, g_lat);
    chk("aborted store rdata", g_rd, 32'd0);
    do_req(0, 1'b0, 16'h0020, 3'b010, 32'h0, g_rd, g_err, g_lat);
    chk("reswept word rdata", g_rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
